// File: rtl/voltmeter_pkg.sv
// Shared voltmeter constants and the scaler tag bundle.
// Used by the scheduler, its arbiter and the bus interface.
package voltmeter_pkg;
    localparam int N_CH    = 13;
    localparam int DATA_W  = 12;
    localparam int CH_W    = 4;
    localparam int SCL_LAT = 2;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } tag_t;
endpackage

// File: rtl/scaler_scheduler_if.sv
// Sample, scaler and result bus of the scaler scheduler.
// slave is the scheduler side, master the environment side.
interface scaler_scheduler_if;
    import voltmeter_pkg::*;

    logic [N_CH-1:0]        req_valid;
    logic [N_CH*DATA_W-1:0] req_data;
    logic                   ovr_clr;
    logic [DATA_W-1:0]      scl_in;
    logic [DATA_W-1:0]      scl_out;
    logic                   res_valid;
    logic [CH_W-1:0]        res_ch;
    logic [DATA_W-1:0]      res_data;
    logic [N_CH*DATA_W-1:0] bank;
    logic [N_CH-1:0]        overrun;
    logic                   busy;

    modport slave (
        input  req_valid, req_data, ovr_clr, scl_out,
        output scl_in, res_valid, res_ch, res_data,
        output bank, overrun, busy
    );

    modport master (
        output req_valid, req_data, ovr_clr, scl_out,
        input  scl_in, res_valid, res_ch, res_data,
        input  bank, overrun, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over the channel pending vector.
// Search starts one past the last granted channel.
module rr_arbiter
    import voltmeter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] idx,
    output logic            any
);
    logic [CH_W-1:0] last;
    logic [CH_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(last) + i) % N_CH);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) gnt = N_CH'(1) << idx;
    end

    // Reset to the top channel so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) last <= CH_W'(N_CH - 1);
        else if (advance && any) last <= idx;
    end
endmodule

// File: rtl/scaler_scheduler.sv
// Shares one voltage scaler across all channels, round-robin.
// Tracks issued channels through the scaler and banks results.
module scaler_scheduler
    import voltmeter_pkg::*;
(
    input logic clk,
    input logic rst,
    scaler_scheduler_if.slave bus
);
    localparam int TAG_D = SCL_LAT + 1;

    logic [N_CH-1:0]   pend;
    logic [DATA_W-1:0] hold [N_CH];
    tag_t              tags [TAG_D];

    logic [N_CH-1:0] gnt;
    logic [N_CH-1:0] ovr_ev;
    logic [CH_W-1:0] gidx;
    logic            gany;

    rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (pend),
        .advance (gany),
        .gnt     (gnt),
        .idx     (gidx),
        .any     (gany)
    );

    assign ovr_ev = bus.req_valid & pend & ~gnt;

    always_comb begin
        bus.busy = |pend;
        for (int i = 0; i < TAG_D; i++) begin
            bus.busy = bus.busy | tags[i].valid;
        end
    end

    // A granted channel issues its old value before a same-cycle reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend          <= '0;
            bus.scl_in    <= '0;
            bus.res_valid <= 1'b0;
            bus.res_ch    <= '0;
            bus.res_data  <= '0;
            bus.bank      <= '0;
            bus.overrun   <= '0;
            for (int k = 0; k < N_CH; k++) hold[k] <= '0;
            for (int i = 0; i < TAG_D; i++) tags[i] <= '0;
        end else begin
            pend <= (pend & ~gnt) | bus.req_valid;
            for (int k = 0; k < N_CH; k++) begin
                if (bus.req_valid[k])
                    hold[k] <= bus.req_data[k*DATA_W +: DATA_W];
            end
            if (bus.ovr_clr) bus.overrun <= ovr_ev;
            else bus.overrun <= bus.overrun | ovr_ev;
            if (gany) bus.scl_in <= hold[gidx];
            tags[0] <= '{valid: gany, ch: gidx};
            for (int i = 1; i < TAG_D; i++) tags[i] <= tags[i-1];
            bus.res_valid <= tags[TAG_D-1].valid;
            if (tags[TAG_D-1].valid) begin
                bus.res_ch   <= tags[TAG_D-1].ch;
                bus.res_data <= bus.scl_out;
                bus.bank[tags[TAG_D-1].ch*DATA_W +: DATA_W] <= bus.scl_out;
            end
        end
    end
endmodule

// File: tb/tb_scaler_scheduler.sv
// Directed bench for scaler_scheduler with a MUL=812 scaler model.
// Scaler: out = in*812/1000, two registered stages.
module tb_scaler_scheduler;
    import voltmeter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    scaler_scheduler_if bus ();

    scaler_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] s1;
    always @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            bus.scl_out <= '0;
        end else begin
            s1 <= DATA_W'((32'(bus.scl_in) * 812) / 1000);
            bus.scl_out <= s1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int ch, input int val);
        bus.req_valid[ch] = 1'b1;
        bus.req_data[ch*DATA_W +: DATA_W] = DATA_W'(val);
    endtask

    task automatic clr_req();
        bus.req_valid = '0;
    endtask

    function automatic logic [31:0] bankv(input int k);
        return 32'(bus.bank[k*DATA_W +: DATA_W]);
    endfunction

    task automatic chk_res(input string tag, input int ch, input int val);
        chk({tag, "_valid"}, 32'(bus.res_valid), 1);
        chk({tag, "_ch"}, 32'(bus.res_ch), ch);
        chk({tag, "_data"}, 32'(bus.res_data), val);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_scl_in"}, 32'(bus.scl_in), 0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_res_ch"}, 32'(bus.res_ch), 0);
        chk({tag, "_res_data"}, 32'(bus.res_data), 0);
        chk({tag, "_bank"}, 32'(bus.bank != '0), 0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    int exp13 [N_CH] = '{0, 243, 487, 730, 974, 1218, 1461,
                         1705, 1948, 2192, 2436, 2679, 3325};

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.ovr_clr   = 1'b0;

        // reset state
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_zero("reset");

        // single request, ch 5
        strobe(5, 1000);
        tick();
        clr_req();
        chk("single_busy_c1", 32'(bus.busy), 1);
        tick(3);
        chk("single_early", 32'(bus.res_valid), 0);
        tick();
        chk_res("single", 5, 812);
        chk("single_bank5", bankv(5), 812);
        tick();
        chk("single_pulse", 32'(bus.res_valid), 0);
        chk("single_busy_c6", 32'(bus.busy), 0);

        // all 13 channels from a fresh arbiter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < N_CH; k++)
            strobe(k, (k == N_CH - 1) ? 4095 : 300 * k);
        tick();
        clr_req();
        tick(4);
        for (int k = 0; k < N_CH; k++) begin
            chk_res($sformatf("all_%0d", k), k, exp13[k]);
            tick();
        end
        chk("all_after", 32'(bus.res_valid), 0);
        chk("all_bank12", bankv(12), 3325);
        chk("all_bank3", bankv(3), 730);
        chk("all_overrun", 32'(bus.overrun), 0);

        // wrap: last=12, ch 12 and ch 0 pending
        strobe(0, 1000);
        strobe(12, 100);
        tick();
        clr_req();
        tick(4);
        chk_res("wrap_first", 0, 812);
        tick();
        chk_res("wrap_second", 12, 81);
        tick();

        // ch 5 granted, then ch 3 and ch 11 pending
        strobe(5, 2000);
        tick();
        clr_req();
        strobe(3, 500);
        strobe(11, 4000);
        tick();
        clr_req();
        tick(3);
        chk_res("rr_ch5", 5, 1624);
        tick();
        chk_res("rr_ch11", 11, 3248);
        tick();
        chk_res("rr_ch3", 3, 406);
        tick();

        // overrun on ch 2 while ch 0/1 contend
        strobe(0, 10);
        strobe(1, 20);
        strobe(2, 2048);
        tick();
        clr_req();
        strobe(2, 4095);
        tick();
        clr_req();
        chk("ovr_flag", 32'(bus.overrun), 32'h4);
        tick(3);
        chk_res("ovr_ch0", 0, 8);
        tick();
        chk_res("ovr_ch1", 1, 16);
        tick();
        chk_res("ovr_ch2", 2, 3325);
        tick();
        chk("ovr_single_result", 32'(bus.res_valid), 0);
        chk("ovr_sticky", 32'(bus.overrun), 32'h4);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", 32'(bus.overrun), 0);

        // same-cycle grant and new request on ch 7
        strobe(7, 100);
        tick();
        strobe(7, 2000);
        tick();
        clr_req();
        tick(3);
        chk_res("same_first", 7, 81);
        tick();
        chk_res("same_second", 7, 1624);
        chk("same_overrun", 32'(bus.overrun), 0);
        tick();
        chk("same_done", 32'(bus.res_valid), 0);

        // reset with three channels in flight
        strobe(1, 1000);
        strobe(2, 2000);
        strobe(3, 500);
        tick();
        clr_req();
        tick(2);
        chk("midrst_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("midrst_quiet_%0d", i), 32'(bus.res_valid), 0);
        end
        chk("midrst_busy_after", 32'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
